// File: rtl/seq_signed_divider.sv
// Sequential two's-complement divider: restoring division on operand magnitudes,
// one quotient bit per clock, signs re-applied in a final FIX cycle.
module seq_signed_divider #(
    parameter int numBit = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [numBit-1:0] dividend_in,
    input  logic [numBit-1:0] divisor_in,
    output logic              busy,
    output logic              done,
    output logic [numBit-1:0] quotient_out,
    output logic [numBit-1:0] remainder_out,
    output logic              div_by_zero
);

    localparam int CW = (numBit > 1) ? $clog2(numBit) : 1;
    localparam logic [numBit-1:0] ONE = {{(numBit-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [numBit-1:0] pr_q, pr_d;
    logic [numBit-1:0] a_q, a_d;
    logic [numBit-1:0] b_q, b_d;
    logic              sgn_q_q, sgn_q_d;
    logic              sgn_r_q, sgn_r_d;
    logic              dz_q, dz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [numBit-1:0] quo_q, quo_d;
    logic [numBit-1:0] rem_q, rem_d;
    logic              dbz_q, dbz_d;

    logic [numBit:0]   shifted_s;
    logic [numBit-1:0] diff_s;
    logic              ge_s;

    // Magnitude of a two's-complement value; the most-negative value maps to 2^(numBit-1).
    function automatic logic [numBit-1:0] mag(input logic [numBit-1:0] v);
        if (v[numBit-1]) begin
            mag = ~v + ONE;
        end else begin
            mag = v;
        end
    endfunction

    // Restoring step: the partial remainder never exceeds the divisor magnitude,
    // so the low numBit bits of the subtraction are exact whenever it is kept.
    always_comb begin
        shifted_s = {pr_q, a_q[numBit-1]};
        ge_s      = (shifted_s >= {1'b0, b_q});
        diff_s    = shifted_s[numBit-1:0] - b_q;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = {CW{1'b0}};
                    pr_d    = {numBit{1'b0}};
                    a_d     = mag(dividend_in);
                    b_d     = mag(divisor_in);
                    sgn_q_d = dividend_in[numBit-1] ^ divisor_in[numBit-1];
                    sgn_r_d = dividend_in[numBit-1];
                    dz_d    = (divisor_in == {numBit{1'b0}});
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            CALC: begin
                if (ge_s) begin
                    pr_d = diff_s;
                end else begin
                    pr_d = shifted_s[numBit-1:0];
                end
                a_d   = {a_q[numBit-2:0], ge_s};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(numBit-1)) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                // With a zero divisor every trial subtraction succeeds, leaving
                // Rmag = |dividend|, so only the quotient needs overriding.
                if (dz_q) begin
                    quo_d = {numBit{1'b1}};
                end else if (sgn_q_q) begin
                    quo_d = ~a_q + ONE;
                end else begin
                    quo_d = a_q;
                end
                if (sgn_r_q) begin
                    rem_d = ~pr_q + ONE;
                end else begin
                    rem_d = pr_q;
                end
                dbz_d   = dz_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            pr_q    <= {numBit{1'b0}};
            a_q     <= {numBit{1'b0}};
            b_q     <= {numBit{1'b0}};
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= {numBit{1'b0}};
            rem_q   <= {numBit{1'b0}};
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign quotient_out  = quo_q;
    assign remainder_out = rem_q;
    assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and exhaustive checks of seq_signed_divider at numBit=4.
module tb_seq_signed_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] dividend_in;
    logic [N-1:0] divisor_in;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient_out;
    logic [N-1:0] remainder_out;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t       vecs[10];
    logic [3:0] res_q[16][16];

    always #5 clk = ~clk;

    seq_signed_divider #(.numBit(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dividend_in  (dividend_in),
        .divisor_in   (divisor_in),
        .busy         (busy),
        .done         (done),
        .quotient_out (quotient_out),
        .remainder_out(remainder_out),
        .div_by_zero  (div_by_zero)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for done; lat counts edges after the accept edge.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic dz, output int lat, output logic busy_acc);
        @(negedge clk);
        start = 1'b1; dividend_in = a; divisor_in = b;
        @(posedge clk); #1;
        start = 1'b0; dividend_in = 4'b0000; divisor_in = 4'b0000;
        busy_acc = busy;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        q = quotient_out; r = remainder_out; dz = div_by_zero;
    endtask

    initial begin
        logic [3:0] q, r, q2, r2;
        logic       dz, dz2, bacc;
        int         lat, lat2;
        int         sa, sb, eq, er;
        logic [3:0] qe, re;
        logic       dseen;

        vecs[0] = '{4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0};
        vecs[1] = '{4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0};
        vecs[2] = '{4'b0101, 4'b1010, 4'b0000, 4'b0101, 1'b0};
        vecs[3] = '{4'b1010, 4'b1110, 4'b0011, 4'b0000, 1'b0};
        vecs[4] = '{4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0};
        vecs[5] = '{4'b0011, 4'b0000, 4'b1111, 4'b0011, 1'b1};
        vecs[6] = '{4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0};
        vecs[7] = '{4'b1000, 4'b0000, 4'b1111, 4'b1000, 1'b1};
        vecs[8] = '{4'b0111, 4'b0111, 4'b0001, 4'b0000, 1'b0};
        vecs[9] = '{4'b1000, 4'b0111, 4'b1111, 4'b1111, 1'b0};

        rst = 1'b1; start = 1'b0; dividend_in = 4'b0000; divisor_in = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_q", int'(quotient_out), 0);
        chk("reset_r", int'(remainder_out), 0);
        chk("reset_dz", int'(div_by_zero), 0);

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, q, r, dz, lat, bacc);
            chk($sformatf("vec%0d_busy", i), int'(bacc), 1);
            chk($sformatf("vec%0d_lat", i), lat, 5);
            chk($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d_r", i), int'(r), int'(vecs[i].r));
            chk($sformatf("vec%0d_dz", i), int'(dz), int'(vecs[i].dz));
            chk($sformatf("vec%0d_busy_done", i), int'(busy), 0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
            chk($sformatf("vec%0d_hold_q", i), int'(quotient_out), int'(vecs[i].q));
        end

        // start during busy is ignored.
        @(negedge clk);
        start = 1'b1; dividend_in = 4'b1001; divisor_in = 4'b0010;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend_in = 4'b0111; divisor_in = 4'b0001;
        @(posedge clk); #1; start = 1'b0;
        lat = 3;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_lat", lat, 5);
        chk("ignore_q", int'(quotient_out), 'hD);
        chk("ignore_r", int'(remainder_out), 'hF);
        dseen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dseen = 1'b1;
        end
        chk("ignore_no_second_op", int'(dseen), 0);

        // Back-to-back: start in the done cycle.
        do_op(4'b0111, 4'b0010, q, r, dz, lat, bacc);
        start = 1'b1; dividend_in = 4'b1010; divisor_in = 4'b0011;
        @(posedge clk); #1; start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        lat2 = 1;
        while (done !== 1'b1 && lat2 < 20) begin
            @(posedge clk); #1;
            lat2++;
        end
        chk("b2b_gap", lat2, 6);
        chk("b2b_q", int'(quotient_out), 'hE);
        chk("b2b_r", int'(remainder_out), 0);

        // Reset in the third CALC cycle, with start asserted alongside it.
        do_op(4'b0111, 4'b0010, q, r, dz, lat, bacc);
        @(negedge clk);
        start = 1'b1; dividend_in = 4'b0110; divisor_in = 4'b0001;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_q", int'(quotient_out), 0);
        chk("rst_mid_r", int'(remainder_out), 0);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        dseen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dseen = 1'b1;
        end
        chk("rst_mid_no_done", int'(dseen), 0);
        do_op(4'b0110, 4'b0011, q, r, dz, lat, bacc);
        chk("rst_fresh_lat", lat, 5);
        chk("rst_fresh_q", int'(q), 2);
        chk("rst_fresh_r", int'(r), 0);

        // Exhaustive sweep against an integer reference model.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(4'(i), 4'(j), q, r, dz, lat, bacc);
                res_q[i][j] = q;
                sa = (i > 7) ? i - 16 : i;
                sb = (j > 7) ? j - 16 : j;
                if (sb == 0) begin
                    qe = 4'b1111; re = 4'(i);
                end else begin
                    eq = sa / sb; er = sa % sb;
                    qe = eq[3:0]; re = er[3:0];
                end
                chk($sformatf("sweep_%0d_%0d", i, j),
                    int'({lat[7:0], 3'b000, dz, q, r}),
                    int'({8'd5, 3'b000, (sb == 0), qe, re}));
                if (sb != 0) begin
                    q2 = 4'(int'($signed(q)) * sb + int'($signed(r)));
                    chk($sformatf("ident_%0d_%0d", i, j), int'(q2), i);
                end
            end
        end

        // Multiplier round trip: (m*n)/n == m whenever m*n fits.
        for (int m = -8; m < 8; m++) begin
            for (int n = -8; n < 8; n++) begin
                if (n != 0 && m * n >= -8 && m * n <= 7) begin
                    q2 = 4'(m);
                    r2 = res_q[(m * n) & 15][n & 15];
                    chk($sformatf("roundtrip_%0d_%0d", m, n), int'(r2), int'(q2));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_signed_divider.md
# seq_signed_divider

Sequential two's-complement divider, the inverse companion of the combinational Baugh-Wooley multiplier in the arithmetic library. It accepts a signed dividend and divisor through a start/done handshake. It produces a signed quotient and remainder using restoring division on magnitudes, one quotient bit per cycle. The block is used where a product from the multiplier must be divided back down, and in self-checking benches as a check on the multiplier, where (m*n)/n must equal m.

## Interface
- numBit, default 4: operand width in bits; both operands and both results are numBit-bit two's complement; numBit >= 2.
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- dividend_in  input  numBit  signed dividend; captured on the accepting edge.
- divisor_in  input  numBit  signed divisor; captured on the accepting edge.
- busy  output  1  high from the accepting edge until the result edge.
- done  output  1  single-cycle pulse; results are valid from this cycle on.
- quotient_out  output  numBit  signed quotient; held until the next result edge.
- remainder_out  output  numBit  signed remainder; held until the next result edge.
- div_by_zero  output  1  error flag for the held result; updated together with quotient_out.

## Operation
- FSM states: IDLE, CALC, FIX.
  - IDLE: with start=1, capture the operands, then go to CALC.
  - CALC: runs exactly numBit cycles, then goes to FIX.
  - FIX: goes to IDLE unconditionally.
- On accept, the block records:
  - sign_q = dividend[MSB] XOR divisor[MSB]
  - sign_r = dividend[MSB]
  - the unsigned magnitudes |dividend| and |divisor|, each numBit bits.
  - |most-negative| = 2^(numBit-1), which is representable unsigned.
  - dz = (divisor == 0).
- CALC performs one restoring step per cycle on a (numBit+1)-bit partial remainder, initialised to 0:
  - shift the next dividend-magnitude bit in, MSB first;
  - trial-subtract |divisor|;
  - if the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- FIX applies the signs and registers the outputs:
  - quotient_out = sign_q ? -Qmag : Qmag, truncated to numBit bits.
  - remainder_out = sign_r ? -Rmag : Rmag.
- Rounding: the quotient truncates toward zero; the remainder takes the sign of the dividend; dividend = q*divisor + r always holds, except in the divide-by-zero case.
- Overflow, most-negative / -1: the quotient wraps to most-negative (e.g. 1000 for numBit=4) and the remainder is 0. No flag is raised.
- Divide by zero: the full latency is still taken; quotient_out = all ones (-1), remainder_out = dividend_in as captured, div_by_zero = 1.
- div_by_zero = 0 for every non-zero divisor.
- start while busy=1 is ignored and has no side effects.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Accepting edge = edge A, where start=1 and the state is IDLE.
- busy = 1 in the cycles after edges A .. A+numBit.
- Result edge = A+numBit+1. After it:
  - done = 1 for exactly one cycle;
  - busy = 0 in that same cycle;
  - the outputs carry the new result.
- Latency is numBit+1 clocks from accept to done, which is 5 for numBit=4.
- Throughput: a start asserted in the done cycle is accepted at the next edge, so back-to-back operations complete one every numBit+2 cycles.
- Reset values: state = IDLE; busy, done, div_by_zero = 0; quotient_out, remainder_out = 0; internal registers = 0.
- Reset has priority over start.
- Reset asserted mid-CALC or mid-FIX aborts the operation: no done pulse, and the previous results are cleared to 0.
- start in the same cycle as rst is ignored.

## Test plan
All scenarios use numBit=4.
- Reset, then idle: after rst is released, all outputs are 0 and busy=0. Then dividend=0111, divisor=0010, start held for 1 cycle -> done exactly 5 edges later, quotient 0011 (3), remainder 0001 (1), div_by_zero=0.
- Sign combinations:
  - 1001 / 0010 (-7/2) -> q=1101 (-3), r=1111 (-1).
  - 0101 / 1010 (5/-6) -> q=0000, r=0101.
  - 1010 / 1110 (-6/-2) -> q=0011, r=0000.
- Overflow and divide by zero:
  - 1000 / 1111 -> q=1000, r=0000, div_by_zero=0.
  - 0011 / 0000 -> q=1111, r=0011, div_by_zero=1.
  - In both cases latency is still 5.
- Handshake:
  - start pulsed again 2 cycles after accept with different operands -> ignored; the first result is unchanged.
  - start asserted in the done cycle -> accepted, and the second done arrives 6 cycles after the first.
- Reset mid-operation: rst asserted on the 3rd CALC cycle -> no done pulse, outputs return to 0, busy=0 on the next cycle. A fresh 0110 / 0011 then gives q=0010, r=0000.
- Exhaustive sweep: all 256 operand pairs with divisor != 0 -> q*divisor + r == dividend (mod 16), |r| < |divisor|, r is 0 or has the dividend's sign. Also check the multiplier round-trip: for every divisor != 0 where m*n fits in 4 bits signed, (m*n)/n returns m.
